// File: rtl/seq_divider.sv
// Sequential radix-2 restoring unsigned divider: one quotient bit per clock,
// launched by iStart, results presented with a one-cycle oDone pulse.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_STEPS = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CW-1:0]    cnt;
  logic             dbzReg;

  // One restoring step: shift {R,Q} left, trial-subtract D with a sign bit
  // to spare so the borrow out of the widened remainder is never lost.
  function automatic logic [2*WIDTH-1:0] restoringStep(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    shifted = {rem, quo[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    if (trial[WIDTH+1]) begin
      restoringStep = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end else begin
      restoringStep = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end
  endfunction

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (iStart) begin
          nextState = RUN;
        end else begin
          nextState = IDLE;
        end
      end
      RUN: begin
        if (cnt == CNT_ZERO) begin
          nextState = DONE;
        end else begin
          nextState = RUN;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register with registered status outputs decoded from next state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      state <= nextState;
      oBusy <= (nextState != IDLE);
      oDone <= (nextState == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result load on the edge into DONE.
  // A zero divisor spends a single RUN cycle with cnt already at zero, so its
  // result appears one edge after launch instead of WIDTH+1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      remReg     <= {WIDTH{1'b0}};
      quoReg     <= {WIDTH{1'b0}};
      divReg     <= {WIDTH{1'b0}};
      cnt        <= CNT_ZERO;
      dbzReg     <= 1'b0;
      oQuotient  <= {WIDTH{1'b0}};
      oRemainder <= {WIDTH{1'b0}};
      oDivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            divReg <= iDivisor;
            quoReg <= iDividend;
            remReg <= {WIDTH{1'b0}};
            if (iDivisor == {WIDTH{1'b0}}) begin
              dbzReg <= 1'b1;
              cnt    <= CNT_ZERO;
            end else begin
              dbzReg <= 1'b0;
              cnt    <= CNT_STEPS;
            end
          end
        end
        RUN: begin
          if (cnt == CNT_ZERO) begin
            oDivByZero <= dbzReg;
            if (dbzReg) begin
              oQuotient  <= {WIDTH{1'b1}};
              oRemainder <= quoReg;
            end else begin
              oQuotient  <= quoReg;
              oRemainder <= remReg;
            end
          end else begin
            {remReg, quoReg} <= restoringStep(remReg, quoReg, divReg);
            cnt              <= cnt - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written
// overlap/reset sequences, and random operands against an arithmetic model.
module tb_seq_divider;

  logic        Clock;
  logic        Reset_n;
  logic        iStart;
  logic [15:0] iDividend;
  logic [15:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oQuotient;
  logic [15:0] oRemainder;
  logic        oDivByZero;

  int compared   = 0;
  int mismatched = 0;

  seq_divider #(.WIDTH(16)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
  } vecT;

  vecT vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one op and wait for oDone; glitchEdge>0 pulses iStart (50/5) before that edge.
  task automatic runOp(input logic [15:0] n, input logic [15:0] d, input int glitchEdge,
                       output logic [15:0] q, output logic [15:0] r, output logic dbz,
                       output int lat, output bit busyOk, output bit stableOk);
    logic [15:0] q0, r0;
    logic        z0;
    @(negedge Clock);
    q0 = oQuotient; r0 = oRemainder; z0 = oDivByZero;
    iDividend = n; iDivisor = d; iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iDividend = 16'($urandom); iDivisor = 16'($urandom);
    lat = -1; busyOk = 1'b1; stableOk = 1'b1;
    q = 16'h0; r = 16'h0; dbz = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e == glitchEdge) begin
        @(negedge Clock);
        iDividend = 16'd50; iDivisor = 16'd5; iStart = 1'b1;
      end
      @(posedge Clock); #1;
      if (e == glitchEdge) iStart = 1'b0;
      if (!oBusy) busyOk = 1'b0;
      if (oDone) begin
        lat = e; q = oQuotient; r = oRemainder; dbz = oDivByZero;
        break;
      end
      if (oQuotient !== q0 || oRemainder !== r0 || oDivByZero !== z0) stableOk = 1'b0;
    end
    @(posedge Clock); #1;
    check("doneWidth", {31'd0, oDone}, 32'd0);
    check("idleBusy", {31'd0, oBusy}, 32'd0);
  endtask

  logic [15:0] gq, gr;
  logic        gz;
  int          glat;
  bit          gBusy, gStable;
  logic [15:0] rn, rd, mq, mr;

  initial begin
    vecs[0] = '{"100/7",       16'd100,    16'd7,      16'd14,     16'd2, 1'b0, 17};
    vecs[1] = '{"FFFF/1",      16'hFFFF,   16'h0001,   16'hFFFF,   16'd0, 1'b0, 17};
    vecs[2] = '{"FFFF/FFFF",   16'hFFFF,   16'hFFFF,   16'd1,      16'd0, 1'b0, 17};
    vecs[3] = '{"5/0",         16'd5,      16'd0,      16'hFFFF,   16'd5, 1'b1, 1};
    vecs[4] = '{"9/3",         16'd9,      16'd3,      16'd3,      16'd0, 1'b0, 17};
    vecs[5] = '{"3/10",        16'd3,      16'd10,     16'd0,      16'd3, 1'b0, 17};
    vecs[6] = '{"0/9",         16'd0,      16'd9,      16'd0,      16'd0, 1'b0, 17};

    Reset_n = 1'b0; iStart = 1'b0; iDividend = 16'h0; iDivisor = 16'h0;
    repeat (3) @(posedge Clock);
    #1;
    check("rstBusy", {31'd0, oBusy}, 32'd0);
    check("rstDone", {31'd0, oDone}, 32'd0);
    check("rstQuot", {16'd0, oQuotient}, 32'd0);
    check("rstRem",  {16'd0, oRemainder}, 32'd0);
    check("rstDbz",  {31'd0, oDivByZero}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < 7; i++) begin
      runOp(vecs[i].n, vecs[i].d, 0, gq, gr, gz, glat, gBusy, gStable);
      check({vecs[i].name, " quot"}, {16'd0, gq}, {16'd0, vecs[i].q});
      check({vecs[i].name, " rem"},  {16'd0, gr}, {16'd0, vecs[i].r});
      check({vecs[i].name, " dbz"},  {31'd0, gz}, {31'd0, vecs[i].dbz});
      check({vecs[i].name, " lat"},  32'(glat), 32'(vecs[i].lat));
      check({vecs[i].name, " busy"}, {31'd0, gBusy}, 32'd1);
      check({vecs[i].name, " hold"}, {31'd0, gStable}, 32'd1);
    end

    // Second start mid-run is ignored; outputs hold until completion edge.
    runOp(16'd200, 16'd9, 6, gq, gr, gz, glat, gBusy, gStable);
    check("ignoreStart quot", {16'd0, gq}, 32'd22);
    check("ignoreStart rem",  {16'd0, gr}, 32'd2);
    check("ignoreStart lat",  32'(glat), 32'd17);
    check("ignoreStart hold", {31'd0, gStable}, 32'd1);

    // Asynchronous reset in the middle of RUN discards the op.
    @(negedge Clock);
    iDividend = 16'd1000; iDivisor = 16'd3; iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    repeat (8) @(posedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midRst busy", {31'd0, oBusy}, 32'd0);
    check("midRst quot", {16'd0, oQuotient}, 32'd0);
    check("midRst rem",  {16'd0, oRemainder}, 32'd0);
    check("midRst dbz",  {31'd0, oDivByZero}, 32'd0);
    gBusy = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge Clock); #1;
      if (oDone) gBusy = 1'b1;
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clock); #1;
      if (oDone || oBusy) gBusy = 1'b1;
    end
    check("midRst noDone", {31'd0, gBusy}, 32'd0);
    runOp(16'd77, 16'd4, 0, gq, gr, gz, glat, gBusy, gStable);
    check("afterRst quot", {16'd0, gq}, 32'd19);
    check("afterRst rem",  {16'd0, gr}, 32'd1);
    check("afterRst lat",  32'(glat), 32'd17);

    // Random operands against plain-arithmetic model.
    for (int i = 0; i < 2000; i++) begin
      rn = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rd = 16'd0;
        1:       rd = 16'($urandom_range(1, 15));
        2:       rd = rn;
        default: rd = 16'($urandom);
      endcase
      if (rd == 16'd0) begin
        mq = 16'hFFFF; mr = rn;
      end else begin
        mq = rn / rd; mr = rn % rd;
      end
      runOp(rn, rd, 0, gq, gr, gz, glat, gBusy, gStable);
      check("rand quot", {16'd0, gq}, {16'd0, mq});
      check("rand rem",  {16'd0, gr}, {16'd0, mr});
      check("rand dbz",  {31'd0, gz}, {31'd0, (rd == 16'd0)});
      check("rand lat",  32'(glat), (rd == 16'd0) ? 32'd1 : 32'd17);
      if (rd != 16'd0) begin
        check("rand invariant", {31'd0, ((32'(gq) * 32'(rd) + 32'(gr)) == 32'(rn)) && (gr < rd)}, 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
